// File: rtl/instr_fetch.sv
// Instruction-fetch front end: fetch PC, single-outstanding imem request,
// prefetch FIFO of {pc, word} entries and redirect/discard handling.
module instr_fetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   r_fifo_pc    [DEPTH];
    logic [31:0]   r_fifo_instr [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_fetch_pc;
    logic          r_req;
    logic [31:0]   r_addr;
    logic          r_discard;

    logic          w_xfer;
    logic          w_hold;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_next;
    logic [31:0]   w_fetch_pc_next;
    logic          w_discard_next;
    logic          w_req_next;
    logic [31:0]   w_addr_next;

    assign instr_valid = (r_count != '0);
    assign instr       = instr_valid ? r_fifo_instr[r_head] : 32'h0;
    assign pc_out      = instr_valid ? r_fifo_pc[r_head]    : 32'h0;
    assign imem_req    = r_req;
    assign imem_addr   = r_addr;

    always_comb begin
        w_xfer = r_req & imem_ack;
        w_hold = r_req & ~imem_ack;
        w_pop  = instr_valid & instr_ready;
        // a word returning for a superseded address never enters the FIFO
        w_push = w_xfer & ~r_discard & ~redirect;

        if (redirect)
            w_count_next = '0;
        else
            w_count_next = r_count + CW'(w_push) - CW'(w_pop);

        if (redirect)
            w_fetch_pc_next = {redirect_pc[31:2], 2'b00};
        else if (w_push)
            w_fetch_pc_next = r_fetch_pc + 32'd4;
        else
            w_fetch_pc_next = r_fetch_pc;

        if (redirect && w_hold)
            w_discard_next = 1'b1;
        else if (w_xfer)
            w_discard_next = 1'b0;
        else
            w_discard_next = r_discard;

        // issuing only when a slot is free reserves space for the reply
        w_req_next  = w_hold ? 1'b1   : (w_count_next < FULL);
        w_addr_next = w_hold ? r_addr : w_fetch_pc_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
            r_discard  <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_req      <= w_req_next;
            r_addr     <= w_addr_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_discard  <= w_discard_next;
            r_count    <= w_count_next;
            if (redirect) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (w_pop)
                    r_head <= r_head + AW'(1);
                if (w_push)
                    r_tail <= r_tail + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_tail]    <= r_fetch_pc;
            r_fifo_instr[r_tail] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: random-latency memory, in-order stream scoreboard,
// directed stall/redirect/wrap/reset scenarios plus a random phase.
module tb_instr_fetch;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic        req5;
    logic [31:0] addr5;
    logic [31:0] instr5;
    logic [31:0] pc5;
    logic        valid5;

    always #5 clk = ~clk;

    instr_fetch #(.DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .pc_out(pc_out), .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    // zero-latency memory, always-ready consumer, start near the top of memory
    instr_fetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut5 (
        .clk(clk), .reset_n(reset_n),
        .imem_req(req5), .imem_addr(addr5),
        .imem_ack(req5), .imem_rdata(addr5 ^ KEY),
        .instr(instr5), .pc_out(pc5), .instr_valid(valid5),
        .instr_ready(1'b1),
        .redirect(1'b0), .redirect_pc(32'h0)
    );

    int          n_tests = 0;
    int          n_fail = 0;
    int          dmin = 1;
    int          dmax = 1;
    int          wait_cnt = 0;
    int          n_xfer = 0;
    int          n_pop = 0;
    bit          busy = 0;
    bit          prev_wait = 0;
    bit          prev_redir = 0;
    bit          redir_ack = 0;
    bit          did_redir = 0;
    logic [31:0] prev_addr = 0;
    logic [31:0] exp_pc = 0;
    logic [31:0] ack_addr = 0;
    logic [31:0] s_addr = 0;
    logic        s_req = 0;
    logic        s_valid = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rdy, input logic rd,
                        input logic [31:0] rpc);
        logic do_rd;
        @(negedge clk);
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = instr_valid;
        if (prev_wait) begin
            check("req_hold", 32'(imem_req), 32'd1);
            check("addr_hold", imem_addr, prev_addr);
        end
        if (prev_redir)
            check("flush_valid", 32'(instr_valid), 32'd0);
        if (imem_req)
            check("addr_align", 32'(imem_addr[1:0]), 32'd0);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (imem_req) begin
            if (!busy) begin
                busy     = 1;
                wait_cnt = $urandom_range(dmax, dmin);
            end
            if (wait_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr ^ KEY;
                busy       = 0;
                ack_addr   = imem_addr;
                n_xfer++;
            end else begin
                wait_cnt--;
            end
        end
        prev_wait = imem_req && !imem_ack;
        prev_addr = imem_addr;
        do_rd = rd | (redir_ack & imem_ack);
        if (instr_valid && rdy) begin
            check("pc_out", pc_out, exp_pc);
            check("instr", instr, exp_pc ^ KEY);
            exp_pc += 32'd4;
            n_pop++;
        end
        if (do_rd) begin
            exp_pc    = {rpc[31:2], 2'b00};
            did_redir = 1;
        end
        instr_ready = rdy;
        redirect    = do_rd;
        redirect_pc = rpc;
        prev_redir  = do_rd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        imem_ack = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        busy = 0;
        prev_wait = 0;
        prev_redir = 0;
        redir_ack = 0;
        exp_pc = 32'h0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] w_pc [3];
        logic [31:0] w_in [3];
        int k;
        int x0;
        int r;

        // reset values
        #12;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc_out, 32'h0);
        check("rst5_addr", addr5, 32'hFFFF_FFF8);
        check("rst5_req", 32'(req5), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // address wrap from a high reset PC
        for (int i = 0; i < 3; i++) begin
            w_pc[i] = 32'hDEAD_BEEF;
            w_in[i] = 32'hDEAD_BEEF;
        end
        k = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (valid5 && k < 3) begin
                w_pc[k] = pc5;
                w_in[k] = instr5;
                k++;
            end
        end
        check("wrap_pc0", w_pc[0], 32'hFFFF_FFF8);
        check("wrap_pc1", w_pc[1], 32'hFFFF_FFFC);
        check("wrap_pc2", w_pc[2], 32'h0000_0000);
        check("wrap_in2", w_in[2], KEY);

        // streaming with a 1-cycle memory
        do_reset();
        dmin = 1; dmax = 1;
        x0 = n_pop;
        repeat (40) step(1'b1, 1'b0, 32'h0);
        check("stream_rate", 32'(n_pop - x0 >= 15), 32'd1);

        // stalled consumer fills exactly DEPTH entries
        do_reset();
        dmin = 0; dmax = 2;
        x0 = n_xfer;
        repeat (30) step(1'b0, 1'b0, 32'h0);
        check("stall_xfers", 32'(n_xfer - x0), 32'd4);
        check("stall_req", 32'(s_req), 32'd0);
        x0 = n_pop;
        repeat (4) begin
            step(1'b1, 1'b0, 32'h0);
            step(1'b0, 1'b0, 32'h0);
        end
        check("stall_pops", 32'(n_pop - x0), 32'd4);
        repeat (20) step(1'b1, 1'b0, 32'h0);

        // redirect while a request is outstanding
        do_reset();
        dmin = 1; dmax = 1;
        repeat (20) step(1'b0, 1'b0, 32'h0);
        check("rd_full_req", 32'(s_req), 32'd0);
        dmin = 3; dmax = 3;
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check("rd_req", 32'(s_req), 32'd1);
        check("rd_addr", s_addr, 32'h10);
        step(1'b0, 1'b1, 32'h100);
        x0 = n_xfer;
        for (int i = 0; i < 10 && n_xfer == x0; i++)
            step(1'b0, 1'b0, 32'h0);
        check("rd_ack_seen", 32'(n_xfer - x0), 32'd1);
        check("rd_ack_addr", ack_addr, 32'h10);
        step(1'b0, 1'b0, 32'h0);
        check("rd_new_req", 32'(s_req), 32'd1);
        check("rd_new_addr", s_addr, 32'h100);
        check("rd_dropped", 32'(s_valid), 32'd0);
        dmin = 0; dmax = 2;
        x0 = n_pop;
        repeat (20) step(1'b1, 1'b0, 32'h0);
        check("rd_resume", 32'(n_pop - x0 > 0), 32'd1);

        // redirect coinciding with the ack
        do_reset();
        dmin = 2; dmax = 2;
        did_redir = 0;
        redir_ack = 1;
        for (int i = 0; i < 10 && !did_redir; i++)
            step(1'b0, 1'b0, 32'h200);
        redir_ack = 0;
        check("ra_done", 32'(did_redir), 32'd1);
        check("ra_ack_addr", ack_addr, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check("ra_empty", 32'(s_valid), 32'd0);
        check("ra_req", 32'(s_req), 32'd1);
        check("ra_addr", s_addr, 32'h200);
        step(1'b0, 1'b1, 32'h103);
        x0 = n_pop;
        repeat (20) step(1'b1, 1'b0, 32'h0);
        check("ra_align_pops", 32'(n_pop - x0 > 0), 32'd1);

        // asynchronous reset mid-request
        do_reset();
        dmin = 3; dmax = 3;
        s_req = 0; s_valid = 0;
        for (int i = 0; i < 40 && !(s_req && s_valid); i++)
            step(1'b0, 1'b0, 32'h0);
        check("ar_setup", 32'(s_req && s_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_req", 32'(imem_req), 32'd0);
        check("ar_valid", 32'(instr_valid), 32'd0);
        check("ar_addr", imem_addr, 32'h0);
        do_reset();
        dmin = 0; dmax = 3;
        x0 = n_pop;
        repeat (30) step(1'b1, 1'b0, 32'h0);
        check("ar_restart", 32'(n_pop - x0 > 0), 32'd1);

        // random traffic
        do_reset();
        dmin = 0; dmax = 3;
        x0 = n_pop;
        repeat (600) begin
            r = $urandom_range(99);
            step(($urandom_range(99) < 70), (r < 4) && !prev_redir, $urandom);
        end
        check("rand_pops", 32'(n_pop - x0 > 50), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
